// File: rtl/fpga_ram_arb.sv
// Two-requester round-robin front end for an internal single-port write-first RAM; Ready is combinational.
// Responses pulse one cycle after the grant. `FPGA_RAM_ARB_INIT_EN adds a zeroing sweep after reset.
module fpga_ram_arb #(
  parameter int DATAWIDTH = 2,
  parameter int ADDRWIDTH = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Req0Valid,
  output logic                 Req0Ready,
  input  logic                 Req0Write,
  input  logic [ADDRWIDTH-1:0] Req0Addr,
  input  logic [DATAWIDTH-1:0] Req0WData,
  output logic                 Rsp0Valid,
  output logic [DATAWIDTH-1:0] Rsp0Data,
  input  logic                 Req1Valid,
  output logic                 Req1Ready,
  input  logic                 Req1Write,
  input  logic [ADDRWIDTH-1:0] Req1Addr,
  input  logic [DATAWIDTH-1:0] Req1WData,
  output logic                 Rsp1Valid,
  output logic [DATAWIDTH-1:0] Rsp1Data,
  output logic                 InitDone
);
  localparam int MEMDEPTH = 2**ADDRWIDTH;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 rsp0_q, rsp1_q;
  logic                 run, gnt0, gnt1;
  logic                 init_wr;
  logic [ADDRWIDTH-1:0] init_addr;
  logic                 ram_we;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [DATAWIDTH-1:0] ram_din;
  logic [DATAWIDTH-1:0] ram_dout_q;
  logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

`ifdef FPGA_RAM_ARB_INIT_EN
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RESET = ST_INIT;

  logic [ADDRWIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                 init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDRWIDTH'(1);
      if (&init_cnt_q) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_wr   = !Rst && (state_q == ST_INIT);
  assign init_addr = init_cnt_q;
  assign InitDone  = init_done_q;
`else
  localparam logic [0:0] ST_RESET = ST_RUN;

  assign state_d   = state_q;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
  assign InitDone  = !Rst;
`endif

  // prio_q == 0 favours requester 0 when both are valid
  assign run  = !Rst && (state_q == ST_RUN);
  assign gnt0 = run && Req0Valid && (!Req1Valid || !prio_q);
  assign gnt1 = run && Req1Valid && (!Req0Valid || prio_q);

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;

  always_comb begin
    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = Req0Addr;
    ram_din  = Req0WData;
    if (init_wr) begin
      ram_we   = 1'b1;
      ram_addr = init_addr;
      ram_din  = '0;
    end else if (gnt1) begin
      ram_we   = Req1Write;
      ram_addr = Req1Addr;
      ram_din  = Req1WData;
    end else if (gnt0) begin
      ram_we   = Req0Write;
    end
  end

  // write-first port: a write returns its own data on dout
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= ram_din;
      ram_dout_q      <= ram_din;
    end else begin
      ram_dout_q <= mem_q[ram_addr];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_RESET;
      prio_q  <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rsp0_q  <= gnt0;
      rsp1_q  <= gnt1;
    end
  end

  assign Rsp0Valid = rsp0_q && !Rst;
  assign Rsp1Valid = rsp1_q && !Rst;
  assign Rsp0Data  = ram_dout_q;
  assign Rsp1Data  = ram_dout_q;

endmodule

// File: tb/tb_fpga_ram_arb.sv
// Bench for fpga_ram_arb (DATAWIDTH=8, ADDRWIDTH=4): directed vector table, reset corners, and
// random traffic scored against a request-level model of the shared RAM.
module tb_fpga_ram_arb;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Req0Valid, Req0Write, Req1Valid, Req1Write;
  logic [AW-1:0] Req0Addr, Req1Addr;
  logic [DW-1:0] Req0WData, Req1WData;
  logic          Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, InitDone;
  logic [DW-1:0] Rsp0Data, Rsp1Data;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  fpga_ram_arb #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Write(Req0Write),
    .Req0Addr(Req0Addr), .Req0WData(Req0WData), .Rsp0Valid(Rsp0Valid), .Rsp0Data(Rsp0Data),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Write(Req1Write),
    .Req1Addr(Req1Addr), .Req1WData(Req1WData), .Rsp1Valid(Rsp1Valid), .Rsp1Data(Rsp1Data),
    .InitDone(InitDone)
  );

  // Request-level model: memory image, fairness pointer, response due next cycle.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_prio = 0;
  int            m_g    = -1;
  bit            p_v0 = 0, p_v1 = 0, p_k0 = 0, p_k1 = 0;
  logic [DW-1:0] p_d0, p_d1;

  typedef struct {
    logic          v0, w0, v1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    rdy, rsp;
    logic [DW-1:0] rd0, rd1;
  } vec_t;
  vec_t vecs[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_g    = -1;
    p_v0   = 0;
    p_v1   = 0;
`ifdef FPGA_RAM_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1;
    end
`endif
  endtask

  // Called mid-cycle (after negedge): score this cycle, then advance the model by one cycle.
  task automatic model_step(input bit do_chk);
    int            g;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    if (do_chk) begin
      chk1("rsp0_vld", Rsp0Valid, p_v0);
      chk1("rsp1_vld", Rsp1Valid, p_v1);
      if (p_v0 && p_k0) chk8("rsp0_dat", Rsp0Data, p_d0);
      if (p_v1 && p_k1) chk8("rsp1_dat", Rsp1Data, p_d1);
    end
    g = -1;
    if (Req0Valid && Req1Valid) g = m_prio;
    else if (Req0Valid)         g = 0;
    else if (Req1Valid)         g = 1;
    if (do_chk) begin
      chk1("rdy0", Req0Ready, g == 0);
      chk1("rdy1", Req1Ready, g == 1);
      chk1("init_done", InitDone, 1'b1);
    end
    p_v0 = (g == 0);
    p_v1 = (g == 1);
    if (g >= 0) begin
      a = (g == 1) ? Req1Addr  : Req0Addr;
      w = (g == 1) ? Req1Write : Req0Write;
      d = (g == 1) ? Req1WData : Req0WData;
      if (w) begin
        m_mem[a]   = d;
        m_known[a] = 1;
      end
      if (g == 0) begin
        p_d0 = m_mem[a];
        p_k0 = m_known[a];
      end else begin
        p_d1 = m_mem[a];
        p_k1 = m_known[a];
      end
      m_prio = 1 - g;
    end
    m_g = g;
  endtask

  task automatic tick(input bit do_chk);
    @(negedge Clk);
    model_step(do_chk);
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    Req0Valid = 0; Req0Write = 0; Req0Addr = '0; Req0WData = '0;
    Req1Valid = 0; Req1Write = 0; Req1Addr = '0; Req1WData = '0;
  endtask

`ifdef FPGA_RAM_ARB_INIT_EN
  // Sweep in progress: nothing granted, no responses, InitDone low for all MEMDEPTH cycles.
  task automatic init_wait();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge Clk);
      chk1("init_busy_done", InitDone, 1'b0);
      chk1("init_busy_rdy0", Req0Ready, 1'b0);
      chk1("init_busy_rdy1", Req1Ready, 1'b0);
      chk1("init_busy_rsp0", Rsp0Valid, 1'b0);
      @(posedge Clk);
      #1;
    end
  endtask
`endif

  task automatic do_reset(input int n);
    Rst = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk1("rst_rdy0", Req0Ready, 1'b0);
      chk1("rst_rdy1", Req1Ready, 1'b0);
      chk1("rst_rsp0", Rsp0Valid, 1'b0);
      chk1("rst_rsp1", Rsp1Valid, 1'b0);
      if (i > 0) chk1("rst_initdone", InitDone, 1'b0);
      @(posedge Clk);
      #1;
    end
    Rst = 0;
    model_reset();
`ifdef FPGA_RAM_ARB_INIT_EN
    init_wait();
`endif
  endtask

  task automatic row(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [1:0] rdy, input logic [1:0] rsp,
                     input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.rsp = rsp; v.rd0 = rd0; v.rd1 = rd1;
    vecs.push_back(v);
  endtask

  initial begin
    // {rdy0,rdy1} and {rsp0,rsp1} are what this cycle must show; Prio is 0 at row 0.
    row(1, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00);
    row(0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 2'b01, 2'b10, 8'hA5, 8'h00);
    row(1, 1, 5, 8'h3C, 0, 0, 0, 8'h00, 2'b10, 2'b01, 8'h00, 8'hA5);
    row(1, 0, 5, 8'h00, 0, 0, 0, 8'h00, 2'b10, 2'b10, 8'h3C, 8'h00);
    row(0, 0, 0, 8'h00, 1, 1, 7, 8'h5A, 2'b01, 2'b10, 8'h3C, 8'h00);
    row(1, 0, 3, 8'h00, 1, 0, 5, 8'h00, 2'b10, 2'b01, 8'h00, 8'h5A);
    row(1, 0, 7, 8'h00, 1, 0, 5, 8'h00, 2'b01, 2'b10, 8'hA5, 8'h00);
    row(1, 0, 7, 8'h00, 1, 0, 3, 8'h00, 2'b10, 2'b01, 8'h00, 8'h3C);
    row(1, 0, 5, 8'h00, 1, 0, 3, 8'h00, 2'b01, 2'b10, 8'h5A, 8'h00);
    row(1, 0, 5, 8'h00, 0, 0, 0, 8'h00, 2'b10, 2'b01, 8'h00, 8'hA5);
    row(0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 2'b01, 2'b10, 8'h3C, 8'h00);
    row(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 2'b01, 8'h00, 8'h5A);
    row(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00);
    row(1, 0, 7, 8'h00, 1, 0, 7, 8'h00, 2'b10, 2'b00, 8'h00, 8'h00);
    row(0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 2'b01, 2'b10, 8'h5A, 8'h00);
    row(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 2'b00, 2'b01, 8'h00, 8'h5A);

    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // Release reset with both requesters already asking for address 0.
    set_idle();
    Req0Valid = 1;
    Req1Valid = 1;
    do_reset(3);
    tick(1);
    Req0Valid = 0;
    tick(1);

    // Read every address (zero after the sweep), then write every address.
    for (int a = 0; a < DEPTH; a++) begin
      set_idle();
      if (a % 2 == 0) begin Req0Valid = 1; Req0Addr = AW'(a); end
      else            begin Req1Valid = 1; Req1Addr = AW'(a); end
      tick(1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_idle();
      if (a % 2 == 0) begin Req0Valid = 1; Req0Write = 1; Req0Addr = AW'(a); Req0WData = DW'($urandom); end
      else            begin Req1Valid = 1; Req1Write = 1; Req1Addr = AW'(a); Req1WData = DW'($urandom); end
      tick(1);
    end
    set_idle();
    tick(1);

    // Reset in the cycle right after a grant: its response must never appear.
    Req0Valid = 1;
    Req0Addr  = 2;
    tick(1);
    set_idle();
    Rst = 1;
    @(negedge Clk);
    chk1("rst_after_gnt_rsp0", Rsp0Valid, 1'b0);
    @(posedge Clk);
    #1;
    do_reset(2);
    tick(1);

`ifdef FPGA_RAM_ARB_INIT_EN
    // Interrupt the sweep when it reaches address 7; it must restart from 0.
    Rst = 1;
    @(posedge Clk);
    #1;
    Rst = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk1("partial_init_done", InitDone, 1'b0);
      @(posedge Clk);
      #1;
    end
    do_reset(1);
    tick(1);
`endif

    // Directed table from a fresh reset.
    do_reset(2);
    for (int i = 0; i < vecs.size(); i++) begin
      Req0Valid = vecs[i].v0; Req0Write = vecs[i].w0; Req0Addr = vecs[i].a0; Req0WData = vecs[i].d0;
      Req1Valid = vecs[i].v1; Req1Write = vecs[i].w1; Req1Addr = vecs[i].a1; Req1WData = vecs[i].d1;
      @(negedge Clk);
      chk1($sformatf("vec%0d_rdy0", i), Req0Ready, vecs[i].rdy[1]);
      chk1($sformatf("vec%0d_rdy1", i), Req1Ready, vecs[i].rdy[0]);
      chk1($sformatf("vec%0d_rsp0", i), Rsp0Valid, vecs[i].rsp[1]);
      chk1($sformatf("vec%0d_rsp1", i), Rsp1Valid, vecs[i].rsp[0]);
      if (vecs[i].rsp[1]) chk8($sformatf("vec%0d_rsp0_dat", i), Rsp0Data, vecs[i].rd0);
      if (vecs[i].rsp[0]) chk8($sformatf("vec%0d_rsp1_dat", i), Rsp1Data, vecs[i].rd1);
      model_step(0);
      @(posedge Clk);
      #1;
    end

    // Random traffic; a request stays put until the model says it was granted.
    set_idle();
    for (int n = 0; n < 500; n++) begin
      if (!Req0Valid || m_g == 0) begin
        Req0Valid = ($urandom_range(0, 9) < 6);
        Req0Write = 1'($urandom_range(0, 1));
        Req0Addr  = AW'($urandom_range(0, DEPTH - 1));
        Req0WData = DW'($urandom);
      end
      if (!Req1Valid || m_g == 1) begin
        Req1Valid = ($urandom_range(0, 9) < 6);
        Req1Write = 1'($urandom_range(0, 1));
        Req1Addr  = AW'($urandom_range(0, DEPTH - 1));
        Req1WData = DW'($urandom);
      end
      tick(1);
    end
    set_idle();
    tick(1);
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
